// File: rtl/disparity_pkg.sv
// rtl/disparity_pkg.sv - shared types, default sizes and index-width helper for the disparity search controller
package disparity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  localparam int MAX_DISP_DEF    = 32;
  localparam int H_RES_DEF       = 320;
  localparam int V_RES_DEF       = 240;
  localparam int SAD_W_DEF       = 16;
  localparam int MAX_OUTST_DEF   = 4;
  localparam int UNIQ_MARGIN_DEF = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int X_W_DEF = idx_w(H_RES_DEF);
  localparam int Y_W_DEF = idx_w(V_RES_DEF);
  localparam int D_W_DEF = idx_w(MAX_DISP_DEF);

endpackage

// File: rtl/disparity_min_tracker.sv
// rtl/disparity_min_tracker.sv - running minimum-cost tracker; with UNIQUENESS_CHECK_EN also a runner-up cost
module disparity_min_tracker
  import disparity_pkg::*;
#(
  parameter int D_W   = D_W_DEF,
  parameter int SAD_W = SAD_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic             i_first,
  input  logic [D_W-1:0]   i_d,
  input  logic [SAD_W-1:0] i_cost,
  output logic [D_W-1:0]   o_best_d,
  output logic [SAD_W-1:0] o_best_cost
`ifdef UNIQUENESS_CHECK_EN
  ,
  output logic [SAD_W-1:0] o_second_cost
`endif
);

  logic [D_W-1:0]   r_best_d;
  logic [SAD_W-1:0] r_best_cost;
  logic             w_take;

  // Strict less-than keeps the lower disparity on ties; the first response always loads.
  assign w_take = i_valid && (i_first || (i_cost < r_best_cost));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_best_d    <= '0;
      r_best_cost <= '1;
    end else if (i_clear) begin
      r_best_d    <= '0;
      r_best_cost <= '1;
    end else if (w_take) begin
      r_best_d    <= i_d;
      r_best_cost <= i_cost;
    end
  end

  assign o_best_d    = r_best_d;
  assign o_best_cost = r_best_cost;

`ifdef UNIQUENESS_CHECK_EN
  localparam logic [D_W:0] ONE = (D_W+1)'(1);

  logic [SAD_W-1:0] r_second_cost;
  logic [D_W:0]     w_d_ext;
  logic [D_W:0]     w_b_ext;
  logic             w_far;

  assign w_d_ext = {1'b0, i_d};
  assign w_b_ext = {1'b0, r_best_d};
  assign w_far   = (w_d_ext > w_b_ext + ONE) || (w_b_ext > w_d_ext + ONE);

  // A displaced best survives as runner-up only if it is not a neighbour of the new best.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_second_cost <= '1;
    end else if (i_clear) begin
      r_second_cost <= '1;
    end else if (i_valid && !i_first) begin
      if (w_take) begin
        if (w_far) begin
          r_second_cost <= r_best_cost;
        end
      end else if (w_far && (i_cost < r_second_cost)) begin
        r_second_cost <= i_cost;
      end
    end
  end

  assign o_second_cost = r_second_cost;
`endif

endmodule

// File: rtl/disparity_search_ctrl.sv
// rtl/disparity_search_ctrl.sv - sequences SAD requests over all disparities of one pixel and reports the best
// Optional macro UNIQUENESS_CHECK_EN enables the runner-up margin confidence flag.
module disparity_search_ctrl
  import disparity_pkg::*;
#(
  parameter int MAX_DISP  = MAX_DISP_DEF,
  parameter int H_RES     = H_RES_DEF,
  parameter int V_RES     = V_RES_DEF,
  parameter int SAD_W     = SAD_W_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
`ifdef UNIQUENESS_CHECK_EN
  ,
  parameter int UNIQ_MARGIN = UNIQ_MARGIN_DEF
`endif
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       px_valid,
  output logic                       px_ready,
  input  logic [idx_w(H_RES)-1:0]    px_x,
  input  logic [idx_w(V_RES)-1:0]    px_y,
  output logic                       sad_req_valid,
  input  logic                       sad_req_ready,
  output logic [idx_w(H_RES)-1:0]    sad_xl,
  output logic [idx_w(H_RES)-1:0]    sad_xr,
  output logic [idx_w(V_RES)-1:0]    sad_y,
  input  logic                       sad_resp_valid,
  input  logic [SAD_W-1:0]           sad_resp_cost,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [idx_w(MAX_DISP)-1:0] disp_out,
  output logic [SAD_W-1:0]           disp_cost,
  output logic                       disp_conf
);

  localparam int X_W = idx_w(H_RES);
  localparam int Y_W = idx_w(V_RES);
  localparam int D_W = idx_w(MAX_DISP);
  localparam int O_W = idx_w(MAX_OUTST + 1);

  state_t           r_state;
  state_t           w_next;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [D_W-1:0]   r_d_limit;
  logic [D_W:0]     r_d_iss;
  logic [D_W:0]     r_d_rcv;
  logic [O_W-1:0]   r_outst;

  logic             w_px_fire;
  logic             w_req_fire;
  logic             w_resp_acc;
  logic             w_resp_dec;
  logic             w_can_issue;
  logic             w_last_req;
  logic             w_last_resp;
  logic             w_rcv_done;
  logic [D_W-1:0]   w_d_limit;
  logic [D_W:0]     w_limit_ext;
  logic [D_W-1:0]   w_best_d;
  logic [SAD_W-1:0] w_best_cost;
  logic             w_conf;

  assign w_limit_ext = {1'b0, r_d_limit};
  assign w_px_fire   = px_valid && px_ready;
  assign w_req_fire  = sad_req_valid && sad_req_ready;
  // Responses outside the search (e.g. stragglers after a reset) never reach the tracker.
  assign w_resp_acc  = sad_resp_valid && ((r_state == ISSUE) || (r_state == DRAIN));
  assign w_resp_dec  = sad_resp_valid && (r_outst != '0);
  assign w_can_issue = (r_d_iss <= w_limit_ext) && (r_outst < O_W'(MAX_OUTST));
  assign w_last_req  = (r_d_iss == w_limit_ext);
  assign w_last_resp = (r_d_rcv == w_limit_ext);
  assign w_rcv_done  = (r_d_rcv == w_limit_ext + (D_W+1)'(1));

  // Clamp so that x - d stays non-negative near the left image edge.
  assign w_d_limit = (px_x >= X_W'(MAX_DISP - 1)) ? D_W'(MAX_DISP - 1) : D_W'(px_x);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    px_ready      = 1'b0;
    sad_req_valid = 1'b0;
    disp_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        px_ready = !rst_in;
        if (px_valid && !rst_in) begin
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        sad_req_valid = w_can_issue;
        if (w_can_issue && sad_req_ready && w_last_req) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        // Leaving on the final response itself lets the result appear one cycle later.
        if ((w_resp_acc && w_last_resp) || w_rcv_done) begin
          w_next = OUTPUT;
        end
      end
      OUTPUT: begin
        disp_valid = 1'b1;
        if (disp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_x       <= '0;
      r_y       <= '0;
      r_d_limit <= '0;
      r_d_iss   <= '0;
      r_d_rcv   <= '0;
    end else if (w_px_fire) begin
      r_x       <= px_x;
      r_y       <= px_y;
      r_d_limit <= w_d_limit;
      r_d_iss   <= '0;
      r_d_rcv   <= '0;
    end else begin
      if (w_req_fire) begin
        r_d_iss <= r_d_iss + (D_W+1)'(1);
      end
      if (w_resp_acc) begin
        r_d_rcv <= r_d_rcv + (D_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_outst <= '0;
    end else begin
      case ({w_req_fire, w_resp_dec})
        2'b10:   r_outst <= r_outst + O_W'(1);
        2'b01:   r_outst <= r_outst - O_W'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

`ifdef UNIQUENESS_CHECK_EN
  logic [SAD_W-1:0] w_second_cost;
  logic [SAD_W:0]   w_gap;
`endif

  disparity_min_tracker #(
    .D_W   (D_W),
    .SAD_W (SAD_W)
  ) u_min_tracker (
    .i_clk         (clk_in),
    .i_rst         (rst_in),
    .i_clear       (w_px_fire),
    .i_valid       (w_resp_acc),
    .i_first       (r_d_rcv == '0),
    .i_d           (r_d_rcv[D_W-1:0]),
    .i_cost        (sad_resp_cost),
    .o_best_d      (w_best_d),
    .o_best_cost   (w_best_cost)
`ifdef UNIQUENESS_CHECK_EN
    ,
    .o_second_cost (w_second_cost)
`endif
  );

`ifdef UNIQUENESS_CHECK_EN
  assign w_gap  = {1'b0, w_second_cost} - {1'b0, w_best_cost};
  assign w_conf = (!w_gap[SAD_W] && (w_gap >= (SAD_W+1)'(UNIQ_MARGIN)))
                  || (w_limit_ext < (D_W+1)'(2));
`else
  assign w_conf = 1'b1;
`endif

  assign sad_xl    = r_x;
  assign sad_xr    = r_x - X_W'(r_d_iss);
  assign sad_y     = r_y;
  assign disp_out  = disp_valid ? w_best_d : '0;
  assign disp_cost = disp_valid ? w_best_cost : '0;
  assign disp_conf = disp_valid && w_conf;

endmodule

// File: tb/tb_disparity_search_ctrl.sv
// tb/tb_disparity_search_ctrl.sv - directed and randomized bench for disparity_search_ctrl
module tb_disparity_search_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        px_valid;
  logic        px_ready;
  logic [8:0]  px_x;
  logic [7:0]  px_y;
  logic        sad_req_valid;
  logic        sad_req_ready;
  logic [8:0]  sad_xl;
  logic [8:0]  sad_xr;
  logic [7:0]  sad_y;
  logic        sad_resp_valid;
  logic [15:0] sad_resp_cost;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_out;
  logic [15:0] disp_cost;
  logic        disp_conf;

`ifdef UNIQUENESS_CHECK_EN
  localparam bit CONF_RANDOM_CHECK = 1'b0;
`else
  localparam bit CONF_RANDOM_CHECK = 1'b1;
`endif

  disparity_search_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .px_valid       (px_valid),
    .px_ready       (px_ready),
    .px_x           (px_x),
    .px_y           (px_y),
    .sad_req_valid  (sad_req_valid),
    .sad_req_ready  (sad_req_ready),
    .sad_xl         (sad_xl),
    .sad_xr         (sad_xr),
    .sad_y          (sad_y),
    .sad_resp_valid (sad_resp_valid),
    .sad_resp_cost  (sad_resp_cost),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_out       (disp_out),
    .disp_cost      (disp_cost),
    .disp_conf      (disp_conf)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          due;
    logic [15:0] cost;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 3;
  bit          stall_en = 1'b0;
  int          cur_x = 0;
  int          cur_y = 0;
  int          bad_addr = 0;
  int          max_infl = 0;
  logic [15:0] cost_tab [0:31];
  rsp_t        pipe [$];
  int          iss_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // SAD unit stand-in: fixed latency, in order, costs looked up by requested disparity.
  always @(negedge clk_in) begin
    int d;
    cyc++;
    sad_req_ready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    sad_resp_valid = 1'b0;
    sad_resp_cost  = '0;
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      sad_resp_valid = 1'b1;
      sad_resp_cost  = pipe[0].cost;
      void'(pipe.pop_front());
    end
    if (sad_req_valid && sad_req_ready) begin
      d = int'(sad_xl) - int'(sad_xr);
      if (int'(sad_xl) != cur_x || int'(sad_y) != cur_y || d < 0 || d > 31) bad_addr++;
      iss_q.push_back(d);
      pipe.push_back('{due: cyc + lat, cost: cost_tab[d[4:0]]});
      if (pipe.size() > max_infl) max_infl = pipe.size();
    end
  end

  function automatic void ref_model(input int lim, output int bd, output int bc, output bit conf);
    int second;
    bd = 0;
    bc = int'(cost_tab[0]);
    for (int d = 1; d <= lim; d++)
      if (int'(cost_tab[d]) < bc) begin
        bd = d;
        bc = int'(cost_tab[d]);
      end
    second = 65535;
    for (int d = 0; d <= lim; d++)
      if ((d < bd - 1 || d > bd + 1) && int'(cost_tab[d]) < second) second = int'(cost_tab[d]);
`ifdef UNIQUENESS_CHECK_EN
    conf = (lim < 2) || (second - bc >= 64);
`else
    conf = 1'b1;
`endif
  endfunction

  task automatic fill_rand(input bit ties);
    for (int d = 0; d < 32; d++)
      cost_tab[d] = ties ? 16'($urandom_range(0, 7) * 10) : 16'($urandom_range(0, 65535));
  endtask

  task automatic run_pixel(input int x, input int y, input int hold, input bit chk_lat, input bit chk_conf);
    int lim, k, bd, bc;
    bit conf, seq_ok, stable;
    lim = (x < 31) ? x : 31;
    ref_model(lim, bd, bc, conf);
    iss_q.delete();
    bad_addr = 0;
    cur_x = x;
    cur_y = y;
    disp_ready = (hold == 0);
    @(negedge clk_in);
    px_valid = 1'b1;
    px_x = 9'(x);
    px_y = 8'(y);
    k = 0;
    while (!px_ready && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    chk("px_ready_idle", px_ready, 1);
    @(negedge clk_in);
    px_valid = 1'b0;
    k = 1;
    while (!disp_valid && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
    chk("disp_valid_seen", disp_valid, 1);
    if (chk_lat) chk("latency", k, lim + 1 + lat + 1);
    chk("disp_out", disp_out, bd);
    chk("disp_cost", disp_cost, bc);
    if (chk_conf) chk("disp_conf", disp_conf, conf);
    chk("px_ready_busy", px_ready, 0);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk_in);
        if (!disp_valid || int'(disp_out) != bd || int'(disp_cost) != bc || px_ready) stable = 1'b0;
      end
      chk("hold_stable", stable, 1);
      disp_ready = 1'b1;
    end
    @(negedge clk_in);
    chk("px_ready_after", px_ready, 1);
    chk("disp_valid_drop", disp_valid, 0);
    seq_ok = (iss_q.size() == lim + 1) && (bad_addr == 0);
    for (int i = 0; i < iss_q.size(); i++)
      if (iss_q[i] != i) seq_ok = 1'b0;
    chk("req_sequence", seq_ok, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    rst_in     = 1'b1;
    px_valid   = 1'b0;
    px_x       = '0;
    px_y       = '0;
    disp_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_px_ready", px_ready, 0);
    chk("rst_sad_req_valid", sad_req_valid, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_cost", disp_cost, 0);
    chk("rst_sad_xr", sad_xr, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("idle_px_ready", px_ready, 1);

    // Descending costs with a deep minimum at d=7, full throughput latency.
    for (int d = 0; d < 32; d++) cost_tab[d] = 16'(500 - 10 * d);
    cost_tab[7] = 16'd20;
    run_pixel(100, 12, 0, 1, 1);

    // Near the left edge: only d=0..5 are legal.
    fill_rand(1'b0);
    run_pixel(5, 3, 0, 1, 1);

    // Tie between d=3 and d=9: lower disparity wins.
    for (int d = 0; d < 32; d++) cost_tab[d] = 16'd100;
    cost_tab[3] = 16'd40;
    cost_tab[9] = 16'd40;
    run_pixel(200, 40, 0, 1, 1);

    // x=0: single candidate whose cost is all-ones.
    cost_tab[0] = 16'hFFFF;
    run_pixel(0, 7, 0, 1, 1);

    // Downstream stall for 10 cycles.
    fill_rand(1'b1);
    run_pixel(50, 100, 10, 1, 1);

    // Reset in the middle of issuing, with three requests in flight.
    fill_rand(1'b0);
    cur_x = 100;
    cur_y = 9;
    disp_ready = 1'b1;
    @(negedge clk_in);
    px_valid = 1'b1;
    px_x = 9'd100;
    px_y = 8'd9;
    @(negedge clk_in);
    px_valid = 1'b0;
    k = 0;
    #1;
    while (pipe.size() != 3 && k < 50) begin
      @(negedge clk_in);
      #1;
      k++;
    end
    chk("three_pending", pipe.size(), 3);
    #1 rst_in = 1'b1;
    #1;
    chk("midrst_sad_req_valid", sad_req_valid, 0);
    chk("midrst_px_ready", px_ready, 0);
    chk("midrst_disp_valid", disp_valid, 0);
    chk("midrst_sad_xl", sad_xl, 0);
    chk("midrst_disp_out", disp_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (8) @(negedge clk_in);
    #1;
    chk("late_resp_drained", pipe.size(), 0);
    chk("late_resp_px_ready", px_ready, 1);
    chk("late_resp_no_req", sad_req_valid, 0);
    chk("late_resp_no_disp", disp_valid, 0);
    fill_rand(1'b0);
    run_pixel(77, 20, 0, 1, 1);

`ifdef UNIQUENESS_CHECK_EN
    for (int d = 0; d < 32; d++) cost_tab[d] = 16'd1000;
    cost_tab[10] = 16'd100;
    cost_tab[20] = 16'd120;
    run_pixel(100, 1, 0, 1, 1);
    cost_tab[20] = 16'd200;
    run_pixel(100, 1, 0, 1, 1);
`endif

    // Random ready stalls with latency equal to the outstanding limit.
    lat = 4;
    stall_en = 1'b1;
    max_infl = 0;
    for (int p = 0; p < 20; p++) begin
      fill_rand(p[0]);
      run_pixel(int'($urandom_range(0, 319)), int'($urandom_range(0, 239)), 0, 0, CONF_RANDOM_CHECK);
    end
    stall_en = 1'b0;
    chk("max_outstanding_le4", (max_infl <= 4), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disparity_search_ctrl.md
Name: disparity_search_ctrl

Overview:
Sequences the shared SAD (sum of absolute differences) window unit across all disparity candidates for one left-image pixel and tracks the minimum-cost candidate. Emits one disparity result per requested pixel. Sits between the pixel scan generator (upstream) and the depth-map frame-buffer writer (downstream). Owns the SAD unit's request port and keeps its pipeline full.

Parameters:
MAX_DISP, 32, number of disparity candidates searched (0..MAX_DISP-1); power of two, at least 2
H_RES, 320, image width in pixels
V_RES, 240, image height in lines
SAD_W, 16, width of the SAD cost value
MAX_OUTST, 4, maximum SAD requests in flight (≥ SAD unit latency for full throughput)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
px_valid  input  1  pixel request valid
px_ready  output  1  controller can accept a pixel request
px_x  input  $clog2(H_RES)  left-image column
px_y  input  $clog2(V_RES)  row
sad_req_valid  output  1  SAD request valid
sad_req_ready  input  1  SAD unit accepts request
sad_xl  output  $clog2(H_RES)  left window column (latched px_x)
sad_xr  output  $clog2(H_RES)  right window column (px_x − d)
sad_y  output  $clog2(V_RES)  row
sad_resp_valid  input  1  SAD result valid; in order, no backpressure
sad_resp_cost  input  SAD_W  SAD result
disp_valid  output  1  result valid
disp_ready  input  1  downstream accepts result
disp_out  output  $clog2(MAX_DISP)  best disparity
disp_cost  output  SAD_W  cost of best disparity
disp_conf  output  1  confidence flag (see Optional Feature)

Behaviour:
- Clocking and reset: single clock; reset asynchronous active-high. Reset values: all outputs 0, state IDLE, counters 0, best_cost all-ones.
- IDLE: px_ready=1. On px_valid&&px_ready:
  - Latch x, y.
  - d_limit = min(MAX_DISP-1, x), so x−d never goes negative.
  - Issue counter d_iss=0, receive counter d_rcv=0, best_cost=all-ones, best_d=0.
  - Go to ISSUE.
- ISSUE:
  - sad_req_valid=1 while d_iss≤d_limit and outstanding<MAX_OUTST.
  - sad_xr = x − d_iss.
  - Request transfers when sad_req_valid&&sad_req_ready; then d_iss increments and outstanding increments.
  - After the request for d_limit transfers, go to DRAIN.
  - Every sad_resp_valid, in any state, decrements outstanding.
  - Simultaneous issue and response in one cycle leave outstanding unchanged.
- Compare (ISSUE and DRAIN):
  - On sad_resp_valid, cost is compared with best_cost, candidate index = d_rcv.
  - Strictly-less comparison replaces best; on ties the lower disparity wins.
  - d_rcv then increments.
- DRAIN: wait until d_rcv == d_limit+1 (all responses in), then go to OUTPUT.
- OUTPUT:
  - disp_valid=1; disp_out, disp_cost, disp_conf held stable until disp_ready.
  - On the handshake, go to IDLE; px_ready rises the next cycle.
- Boundary cases:
  - x=0: exactly one candidate; disp_out=0, disp_cost = that cost.
  - A cost equal to all-ones still replaces the initial best on the first response (d_rcv==0 loads unconditionally).
  - Unexpected sad_resp_valid in IDLE or OUTPUT is ignored.
- Timing: the best-disparity register updates the cycle after a response. disp_valid asserts 1 cycle after the last response.
- Throughput: with SAD latency L ≤ MAX_OUTST, ready held 1 and no downstream stall, per-pixel latency from px handshake to disp_valid is (d_limit+1)+L+1 cycles.
- Reset mid-operation clears all state and drops sad_req_valid and disp_valid asynchronously. In-flight SAD responses after reset are ignored because state is IDLE.

Optional Feature:
Macro UNIQUENESS_CHECK_EN, parameter UNIQ_MARGIN (default 64).
- Defined:
  - Also track second_cost, the lowest cost among candidates other than the best, excluding neighbours |d−best_d|≤1.
  - Neighbours are excluded at output time by tracking per-candidate minima outside the window. The implementation keeps the best cost with d outside best_d±1 by re-evaluating when best changes: the old best becomes a second candidate if |old−new|>1.
  - disp_conf = (second_cost − best_cost ≥ UNIQ_MARGIN) or (d_limit < 2).
- Not defined: disp_conf tied 1, no extra registers.

Decomposition:
- Package disparity_pkg: state enum (IDLE, ISSUE, DRAIN, OUTPUT), MAX_DISP, H_RES/V_RES defaults, derived index widths.
- One sub-module, disparity_min_tracker: holds best/second cost and index, with load/compare/clear inputs. The controller FSM and counters stay in the parent.

Test Plan:
- x=100, costs for d=0..31 = 500−10·d except d=7 → 20; sad_req_ready=1, L=3 → disp_out=7, disp_cost=20, disp_valid at cycle 32+3+1 after handshake.
- x=5 → exactly 6 SAD requests, sad_xr = 5,4,3,2,1,0; never wraps.
- Equal costs 40 at d=3 and d=9, all others 100 → disp_out=3.
- Random sad_req_ready stalls, L=4, MAX_OUTST=4 → outstanding never exceeds 4; every request transfers once; result matches reference model.
- disp_ready held 0 for 10 cycles → outputs stable, px_ready=0; release → px_ready=1 the next cycle.
- Assert rst_in during ISSUE with 3 responses pending → all outputs 0 immediately; late responses ignored; next pixel result correct.
- UNIQUENESS_CHECK_EN: best 100 at d=10, second 120 at d=20 → disp_conf=0; second 200 → disp_conf=1.
